// File: rtl/raster_pkg.sv
// Shared types and constants for the triangle rasterizer.
// Q16.16 vertex format, end-of-triangle status codes, fragment record and FSM states.
package raster_pkg;

    localparam int          FRAC_BITS   = 16;
    localparam logic [31:0] FIX_ONE     = 32'h0001_0000;
    localparam int          FRAG_EDGE_W = 40;

    typedef enum logic [1:0] {
        RAST_OK        = 2'd0,
        RAST_CULLED    = 2'd1,
        RAST_OFFSCREEN = 2'd2
    } rast_status_t;

    typedef struct packed {
        logic [15:0]                        x;
        logic [15:0]                        y;
        logic signed [2:0][FRAG_EDGE_W-1:0] w;
        logic signed [FRAG_EDGE_W-1:0]      area;
    } frag_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CLAMP,
        S_EDGE_INIT,
        S_SCAN,
        S_DONE
    } rast_state_t;

endpackage

// File: rtl/triangle_rasterizer_edge_eval.sv
// Combinational edge function edge(a,b,p) with its per-pixel x and y increments.
// Zero latency; no flow control.
module edge_eval #(
    parameter int IW = 16,
    parameter int EW = 40
) (
    input  logic signed [IW-1:0] ax,
    input  logic signed [IW-1:0] ay,
    input  logic signed [IW-1:0] bx,
    input  logic signed [IW-1:0] by,
    input  logic signed [IW-1:0] px,
    input  logic signed [IW-1:0] py,
    output logic signed [EW-1:0] value,
    output logic signed [EW-1:0] step_x,
    output logic signed [EW-1:0] step_y
);

    logic signed [EW-1:0] dx;
    logic signed [EW-1:0] dy;
    logic signed [EW-1:0] qx;
    logic signed [EW-1:0] qy;

    always_comb begin
        dx     = EW'(bx) - EW'(ax);
        dy     = EW'(by) - EW'(ay);
        qx     = EW'(px) - EW'(ax);
        qy     = EW'(py) - EW'(ay);
        value  = dx * qy - dy * qx;
        step_x = -dy;
        step_y = dx;
    end

endmodule

// File: rtl/triangle_rasterizer.sv
// Triangle rasterizer: area cull, framebuffer-clamped bbox, raster scan with incremental edges.
// First candidate 4 cycles after start; a held fragment (frag_valid && !frag_ready) freezes the scan.
module triangle_rasterizer
    import raster_pkg::*;
#(
    parameter int COORD_WIDTH = 32,
    parameter int FB_WIDTH    = 320,
    parameter int FB_HEIGHT   = 180,
    parameter int EDGE_WIDTH  = 40
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic                                     start,
    input  logic signed [2:0][2:0][COORD_WIDTH-1:0]  tri_verts,
    output logic                                     busy,
    output logic                                     done,
    output logic [1:0]                               status,
    output logic                                     frag_valid,
    input  logic                                     frag_ready,
    output logic [15:0]                              frag_x,
    output logic [15:0]                              frag_y,
    output logic signed [2:0][EDGE_WIDTH-1:0]        frag_w,
    output logic signed [EDGE_WIDTH-1:0]             frag_area
);

    localparam int IW = COORD_WIDTH - FRAC_BITS;
    localparam logic signed [IW-1:0] X_LIM = IW'(FB_WIDTH - 1);
    localparam logic signed [IW-1:0] Y_LIM = IW'(FB_HEIGHT - 1);

    rast_state_t state_q, state_d;

    logic signed [IW-1:0]         vx_q [3];
    logic signed [IW-1:0]         vy_q [3];
    logic signed [EDGE_WIDTH-1:0] area_q;
    logic signed [IW-1:0]         xmin_q, xmax_q, ymin_q, ymax_q;
    logic signed [IW-1:0]         cx_q, cy_q;
    logic signed [EDGE_WIDTH-1:0] row_w [3];
    logic signed [EDGE_WIDTH-1:0] cur_w [3];
    logic                         last_q;
    logic                         frag_valid_q;
    frag_t                        frag_q;
    rast_status_t                 status_q;

    logic signed [EDGE_WIDTH-1:0] e_val [3];
    logic signed [EDGE_WIDTH-1:0] e_sx  [3];
    logic signed [EDGE_WIDTH-1:0] e_sy  [3];
    logic signed [IW-1:0]         px, py;
    logic signed [IW-1:0]         rxmin, rxmax, rymin, rymax;
    logic signed [IW-1:0]         cxmin, cxmax, cymin, cymax;
    logic                         box_empty;
    logic                         covered;
    logic                         at_end;
    logic                         row_end;
    logic                         stall;

    // z and the fractional bits play no part in coverage.
    logic unused_bits;
    assign unused_bits = ^{tri_verts[0][2], tri_verts[1][2], tri_verts[2][2],
                           tri_verts[0][0][FRAC_BITS-1:0], tri_verts[0][1][FRAC_BITS-1:0],
                           tri_verts[1][0][FRAC_BITS-1:0], tri_verts[1][1][FRAC_BITS-1:0],
                           tri_verts[2][0][FRAC_BITS-1:0], tri_verts[2][1][FRAC_BITS-1:0]};

    // Edge 2 evaluated at v2 during SETUP yields the triangle area.
    assign px = (state_q == S_SETUP) ? vx_q[2] : xmin_q;
    assign py = (state_q == S_SETUP) ? vy_q[2] : ymin_q;

    edge_eval #(.IW(IW), .EW(EDGE_WIDTH)) u_edge0 (
        .ax(vx_q[1]), .ay(vy_q[1]), .bx(vx_q[2]), .by(vy_q[2]), .px(px), .py(py),
        .value(e_val[0]), .step_x(e_sx[0]), .step_y(e_sy[0])
    );
    edge_eval #(.IW(IW), .EW(EDGE_WIDTH)) u_edge1 (
        .ax(vx_q[2]), .ay(vy_q[2]), .bx(vx_q[0]), .by(vy_q[0]), .px(px), .py(py),
        .value(e_val[1]), .step_x(e_sx[1]), .step_y(e_sy[1])
    );
    edge_eval #(.IW(IW), .EW(EDGE_WIDTH)) u_edge2 (
        .ax(vx_q[0]), .ay(vy_q[0]), .bx(vx_q[1]), .by(vy_q[1]), .px(px), .py(py),
        .value(e_val[2]), .step_x(e_sx[2]), .step_y(e_sy[2])
    );

    always_comb begin
        rxmin = vx_q[0];
        rxmax = vx_q[0];
        rymin = vy_q[0];
        rymax = vy_q[0];
        for (int i = 1; i < 3; i++) begin
            if (vx_q[i] < rxmin) rxmin = vx_q[i];
            if (vx_q[i] > rxmax) rxmax = vx_q[i];
            if (vy_q[i] < rymin) rymin = vy_q[i];
            if (vy_q[i] > rymax) rymax = vy_q[i];
        end
        cxmin     = (xmin_q < 0)     ? {IW{1'b0}} : xmin_q;
        cymin     = (ymin_q < 0)     ? {IW{1'b0}} : ymin_q;
        cxmax     = (xmax_q > X_LIM) ? X_LIM      : xmax_q;
        cymax     = (ymax_q > Y_LIM) ? Y_LIM      : ymax_q;
        box_empty = (cxmin > cxmax) || (cymin > cymax);
        covered   = ~(cur_w[0][EDGE_WIDTH-1] | cur_w[1][EDGE_WIDTH-1] | cur_w[2][EDGE_WIDTH-1]);
        row_end   = (cx_q == xmax_q);
        at_end    = row_end && (cy_q == ymax_q);
        stall     = frag_valid_q && !frag_ready;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE:      if (start) state_d = S_SETUP;
            S_SETUP: begin
                busy    = 1'b1;
                state_d = S_CLAMP;
            end
            S_CLAMP: begin
                busy    = 1'b1;
                state_d = (area_q <= 0 || box_empty) ? S_DONE : S_EDGE_INIT;
            end
            S_EDGE_INIT: begin
                busy    = 1'b1;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                busy = 1'b1;
                if (last_q) begin
                    if (!stall) state_d = S_DONE;
                end else if (!stall && at_end && !covered) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int k = 0; k < 3; k++) begin
                vx_q[k]  <= '0;
                vy_q[k]  <= '0;
                row_w[k] <= '0;
                cur_w[k] <= '0;
            end
            area_q       <= '0;
            xmin_q       <= '0;
            xmax_q       <= '0;
            ymin_q       <= '0;
            ymax_q       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            last_q       <= 1'b0;
            frag_valid_q <= 1'b0;
            frag_q       <= '0;
            status_q     <= RAST_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 3; k++) begin
                            vx_q[k] <= tri_verts[k][0][COORD_WIDTH-1 -: IW];
                            vy_q[k] <= tri_verts[k][1][COORD_WIDTH-1 -: IW];
                        end
                    end
                end
                S_SETUP: begin
                    area_q <= e_val[2];
                    xmin_q <= rxmin;
                    xmax_q <= rxmax;
                    ymin_q <= rymin;
                    ymax_q <= rymax;
                end
                S_CLAMP: begin
                    xmin_q <= cxmin;
                    xmax_q <= cxmax;
                    ymin_q <= cymin;
                    ymax_q <= cymax;
                    last_q <= 1'b0;
                    if (area_q <= 0)    status_q <= RAST_CULLED;
                    else if (box_empty) status_q <= RAST_OFFSCREEN;
                end
                S_EDGE_INIT: begin
                    cx_q        <= xmin_q;
                    cy_q        <= ymin_q;
                    frag_q.area <= area_q;
                    for (int k = 0; k < 3; k++) begin
                        row_w[k] <= e_val[k];
                        cur_w[k] <= e_val[k];
                    end
                end
                S_SCAN: begin
                    if (!stall) begin
                        if (last_q) begin
                            frag_valid_q <= 1'b0;
                        end else begin
                            frag_valid_q <= covered;
                            if (covered) begin
                                frag_q.x <= 16'(cx_q);
                                frag_q.y <= 16'(cy_q);
                                for (int k = 0; k < 3; k++) frag_q.w[k] <= cur_w[k];
                            end
                            if (at_end) begin
                                last_q   <= 1'b1;
                                status_q <= RAST_OK;
                            end else if (row_end) begin
                                cx_q <= xmin_q;
                                cy_q <= cy_q + IW'(1);
                                for (int k = 0; k < 3; k++) begin
                                    row_w[k] <= row_w[k] + e_sy[k];
                                    cur_w[k] <= row_w[k] + e_sy[k];
                                end
                            end else begin
                                cx_q <= cx_q + IW'(1);
                                for (int k = 0; k < 3; k++) cur_w[k] <= cur_w[k] + e_sx[k];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign status     = status_q;
    assign frag_valid = frag_valid_q;
    assign frag_x     = frag_q.x;
    assign frag_y     = frag_q.y;
    assign frag_w     = frag_q.w;
    assign frag_area  = frag_q.area;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Scoreboard bench for triangle_rasterizer: reference rasterizer fills the expected queue,
// a negedge monitor pops and compares every accepted fragment.
module tb_triangle_rasterizer;

    localparam int CW = 32;
    localparam int EW = 40;

    logic                          clk_in = 1'b0;
    logic                          rst_in = 1'b0;
    logic                          start = 1'b0;
    logic                          frag_ready = 1'b0;
    logic signed [2:0][2:0][CW-1:0] tri_verts = '0;
    logic                          busy, done, frag_valid;
    logic [1:0]                    status;
    logic [15:0]                   frag_x, frag_y;
    logic signed [2:0][EW-1:0]     frag_w;
    logic signed [EW-1:0]          frag_area;

    triangle_rasterizer #(.COORD_WIDTH(CW), .FB_WIDTH(320), .FB_HEIGHT(180), .EDGE_WIDTH(EW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .tri_verts(tri_verts),
        .busy(busy), .done(done), .status(status), .frag_valid(frag_valid),
        .frag_ready(frag_ready), .frag_x(frag_x), .frag_y(frag_y),
        .frag_w(frag_w), .frag_area(frag_area)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int     x;
        int     y;
        longint w0;
        longint w1;
        longint w2;
        longint area;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     frag_seen = 0;
    int     exp_status = 0;
    int     exp_count = 0;
    int     first_x, first_y;
    longint first_w0, first_w1, first_w2;

    logic                      stall_prev = 1'b0;
    logic [15:0]               hold_x, hold_y;
    logic signed [2:0][EW-1:0] hold_w;

    function automatic longint edge_f(longint ax, longint ay, longint bx, longint by,
                                      longint px, longint py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    always @(negedge clk_in) begin
        if (!rst_in) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (frag_valid !== 1'b1 || frag_x !== hold_x || frag_y !== hold_y || frag_w !== hold_w) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b x=%0d y=%0d, required held x=%0d y=%0d",
                             frag_valid, frag_x, frag_y, hold_x, hold_y);
                end
            end
            if (frag_valid && frag_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frag: got (%0d,%0d), required no fragment", frag_x, frag_y);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'(frag_x) !== e.x || int'(frag_y) !== e.y ||
                        longint'($signed(frag_w[0])) !== e.w0 || longint'($signed(frag_w[1])) !== e.w1 ||
                        longint'($signed(frag_w[2])) !== e.w2 || longint'(frag_area) !== e.area) begin
                        errors++;
                        $display("FAIL frag: got (%0d,%0d) w=(%0d,%0d,%0d) a=%0d, required (%0d,%0d) w=(%0d,%0d,%0d) a=%0d",
                                 frag_x, frag_y, $signed(frag_w[0]), $signed(frag_w[1]), $signed(frag_w[2]),
                                 frag_area, e.x, e.y, e.w0, e.w1, e.w2, e.area);
                    end
                end
                if (frag_seen == 0) begin
                    first_x  = int'(frag_x);
                    first_y  = int'(frag_y);
                    first_w0 = longint'($signed(frag_w[0]));
                    first_w1 = longint'($signed(frag_w[1]));
                    first_w2 = longint'($signed(frag_w[2]));
                end
                frag_seen++;
            end
            stall_prev = frag_valid && !frag_ready;
            hold_x = frag_x;
            hold_y = frag_y;
            hold_w = frag_w;
        end
    end

    task automatic load_tri(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2);
        int     xs[3];
        int     ys[3];
        int     bx0, bx1, by0, by1;
        longint area;
        xs = '{x0, x1, x2};
        ys = '{y0, y1, y2};
        for (int i = 0; i < 3; i++) begin
            tri_verts[i][0] = {xs[i][15:0], 16'($urandom)};
            tri_verts[i][1] = {ys[i][15:0], 16'($urandom)};
            tri_verts[i][2] = $urandom;
        end
        exp_q.delete();
        frag_seen = 0;
        first_x = -1;
        first_y = -1;
        area = edge_f(x0, y0, x1, y1, x2, y2);
        if (area <= 0) begin
            exp_status = 1;
        end else begin
            bx0 = x0; bx1 = x0; by0 = y0; by1 = y0;
            for (int i = 1; i < 3; i++) begin
                if (xs[i] < bx0) bx0 = xs[i];
                if (xs[i] > bx1) bx1 = xs[i];
                if (ys[i] < by0) by0 = ys[i];
                if (ys[i] > by1) by1 = ys[i];
            end
            if (bx0 < 0) bx0 = 0;
            if (by0 < 0) by0 = 0;
            if (bx1 > 319) bx1 = 319;
            if (by1 > 179) by1 = 179;
            if (bx0 > bx1 || by0 > by1) begin
                exp_status = 2;
            end else begin
                exp_status = 0;
                for (int y = by0; y <= by1; y++) begin
                    for (int x = bx0; x <= bx1; x++) begin
                        longint w0, w1, w2;
                        w0 = edge_f(x1, y1, x2, y2, x, y);
                        w1 = edge_f(x2, y2, x0, y0, x, y);
                        w2 = edge_f(x0, y0, x1, y1, x, y);
                        if (w0 >= 0 && w1 >= 0 && w2 >= 0)
                            exp_q.push_back('{x, y, w0, w1, w2, area});
                    end
                end
            end
        end
        exp_count = exp_q.size();
    endtask

    // mode 0: frag_ready always high; mode 1: high one cycle in three.
    task automatic run_tri(input int mode, input int inject_cyc, input int budget,
                           output int done_cyc, output int done_cnt, output int stat_at_done,
                           output int busy_at1, output int vld_at5);
        int cyc;
        done_cyc = -1; done_cnt = 0; stat_at_done = -1; busy_at1 = -1; vld_at5 = -1;
        @(posedge clk_in); #1;
        start = 1'b1;
        frag_ready = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < budget) begin
            if (cyc == 1) busy_at1 = int'(busy);
            if (cyc == 5) vld_at5 = int'(frag_valid);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    stat_at_done = int'(status);
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (cyc == inject_cyc) begin
                start = 1'b1;
                for (int i = 0; i < 3; i++) tri_verts[i][0] = $urandom;
            end else begin
                start = 1'b0;
            end
            frag_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            @(posedge clk_in); #1;
            cyc++;
        end
        start = 1'b0;
        frag_ready = 1'b1;
    endtask

    task automatic check_end(input string name, input int done_cnt, input int stat_at_done,
                             input int want_frags);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt);
        end
        checks++;
        if (stat_at_done !== exp_status) begin
            errors++;
            $display("FAIL %s_status: got %0d, required %0d", name, stat_at_done, exp_status);
        end
        checks++;
        if (frag_seen !== want_frags || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_frag_count: got %0d (left %0d), required %0d", name, frag_seen,
                     exp_q.size(), want_frags);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || frag_valid !== 1'b0 || status !== 2'd0 ||
            frag_x !== 16'd0 || frag_y !== 16'd0 || frag_w !== '0 || frag_area !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b done=%0b vld=%0b st=%0d x=%0d y=%0d, required all 0",
                     busy, done, frag_valid, status, frag_x, frag_y);
        end
        rst_in = 1'b1;
    endtask

    task automatic test_coverage();
        int dc, dn, st, b1, v5;
        load_tri(10, 10, 20, 10, 10, 20);
        run_tri(0, -1, 2000, dc, dn, st, b1, v5);
        check_end("coverage", dn, st, 66);
        checks++;
        if (b1 !== 1 || v5 !== 1) begin
            errors++;
            $display("FAIL coverage_latency: got busy@1=%0d valid@5=%0d, required 1 1", b1, v5);
        end
        checks++;
        if (first_x !== 10 || first_y !== 10 || first_w0 !== 100 || first_w1 !== 0 || first_w2 !== 0) begin
            errors++;
            $display("FAIL coverage_first: got (%0d,%0d) w=(%0d,%0d,%0d), required (10,10) w=(100,0,0)",
                     first_x, first_y, first_w0, first_w1, first_w2);
        end
        checks++;
        if (frag_area !== 40'sd100) begin
            errors++;
            $display("FAIL coverage_area: got %0d, required 100", frag_area);
        end
    endtask

    task automatic test_reject(input string name, input int x0, input int y0, input int x1,
                               input int y1, input int x2, input int y2, input int want_status);
        int dc, dn, st, b1, v5;
        load_tri(x0, y0, x1, y1, x2, y2);
        run_tri(0, -1, 200, dc, dn, st, b1, v5);
        check_end(name, dn, st, 0);
        checks++;
        if (dc !== 3 || st !== want_status) begin
            errors++;
            $display("FAIL %s_timing: got done@%0d status=%0d, required done@3 status=%0d",
                     name, dc, st, want_status);
        end
    endtask

    task automatic test_clip();
        int dc, dn, st, b1, v5;
        load_tri(-5, -5, 5, -5, -5, 5);
        run_tri(0, -1, 500, dc, dn, st, b1, v5);
        check_end("clip", dn, st, 1);
        checks++;
        if (first_x !== 0 || first_y !== 0 || st !== 0) begin
            errors++;
            $display("FAIL clip_pixel: got (%0d,%0d) status=%0d, required (0,0) status=0",
                     first_x, first_y, st);
        end
    endtask

    task automatic test_backpressure();
        int dc, dn, st, b1, v5;
        load_tri(10, 10, 20, 10, 10, 20);
        run_tri(1, -1, 3000, dc, dn, st, b1, v5);
        check_end("backpressure", dn, st, 66);
    endtask

    task automatic test_busy_start();
        int dc, dn, st, b1, v5;
        load_tri(10, 10, 20, 10, 10, 20);
        run_tri(0, 12, 2000, dc, dn, st, b1, v5);
        check_end("busy_start", dn, st, 66);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle: got busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int dc, dn, st, b1, v5;
        load_tri(30, 5, 50, 25, 12, 40);
        run_tri(0, -1, 4000, dc, dn, st, b1, v5);
        check_end("b2b_a", dn, st, exp_count);
        load_tri(310, 170, 330, 175, 305, 190);
        run_tri(1, -1, 4000, dc, dn, st, b1, v5);
        check_end("b2b_b", dn, st, exp_count);
    endtask

    task automatic test_reset_repeat();
        int dc, dn, st, b1, v5;
        int done_seen;
        load_tri(10, 10, 20, 10, 10, 20);
        @(posedge clk_in); #1;
        start = 1'b1;
        frag_ready = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        repeat (20) @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || frag_valid !== 1'b0 || status !== 2'd0 ||
            frag_x !== 16'd0 || frag_y !== 16'd0 || frag_w !== '0 || frag_area !== '0) begin
            errors++;
            $display("FAIL midscan_reset: got busy=%0b vld=%0b x=%0d y=%0d, required all 0",
                     busy, frag_valid, frag_x, frag_y);
        end
        exp_q.delete();
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        done_seen = 0;
        repeat (4) begin
            @(posedge clk_in); #1;
            if (done || frag_valid) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL abandoned_triangle: got %0d done/valid cycles, required 0", done_seen);
        end
        load_tri(0, 0, 8, 0, 0, 8);
        run_tri(0, -1, 1000, dc, dn, st, b1, v5);
        check_end("repeat", dn, st, 45);
        checks++;
        if (first_x !== 0 || first_y !== 0 || first_w0 !== 64 || first_w1 !== 0 || first_w2 !== 0) begin
            errors++;
            $display("FAIL repeat_first: got (%0d,%0d) w=(%0d,%0d,%0d), required (0,0) w=(64,0,0)",
                     first_x, first_y, first_w0, first_w1, first_w2);
        end
    endtask

    initial begin
        test_reset();
        test_coverage();
        test_reject("cull", 10, 10, 10, 20, 20, 10, 1);
        test_reject("offscreen", 400, 10, 410, 10, 400, 20, 2);
        test_clip();
        test_backpressure();
        test_busy_start();
        test_back_to_back();
        test_reset_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/triangle_rasterizer.md
Name: triangle_rasterizer

Overview:
- Stage directly downstream of the triangle projection stage.
- Consumes one screen-space triangle (three vertices, Q16.16 x/y/z) and applies area-based back-face/degenerate culling.
- Computes a framebuffer-clamped bounding box, then scans it in raster order with incremental edge functions.
- Emits one fragment per covered pixel over a valid/ready stream to the depth-test/shading stage.

Parameters:
- COORD_WIDTH, 32, vertex coordinate width, Q16.16 signed.
- FB_WIDTH, 320, framebuffer width in pixels.
- FB_HEIGHT, 180, framebuffer height in pixels.
- EDGE_WIDTH, 40, signed width of edge-function and area accumulators.

Ports:
- clk_in  in  1  single clock.
- rst_in  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; accepted only in IDLE, ignored otherwise.
- tri_verts  in  [2:0][2:0][COORD_WIDTH-1:0] signed  vertex i, component c (0=x, 1=y, 2=z); sampled on the start cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of each triangle, whether rasterized or rejected.
- status  out  2  0 = rasterized, 1 = culled (area<=0), 2 = bbox empty after clamp; valid with done, held until next start.
- frag_valid  out  1  fragment available.
- frag_ready  in  1  downstream accepts the fragment when frag_valid && frag_ready.
- frag_x  out  16  pixel x.
- frag_y  out  16  pixel y.
- frag_w  out  [2:0][EDGE_WIDTH-1:0] signed  edge values w0, w1, w2 at the pixel (barycentric numerators).
- frag_area  out  EDGE_WIDTH signed  triangle area (denominator); constant per triangle.

Behaviour:
- Reset (rst_in low, asynchronous) drives state to IDLE and clears busy, done, frag_valid, status, frag_x, frag_y, frag_w and frag_area to 0.
- Reset mid-scan abandons the triangle: no done pulse and no further fragments.
- Integer vertex coordinate = Q16.16 value arithmetic-shifted right by 16 (floor); z is ignored here.
- Edge function: edge(a,b,p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax), evaluated at EDGE_WIDTH.
- w0 = edge(v1,v2,p), w1 = edge(v2,v0,p), w2 = edge(v0,v1,p).
- area = edge(v0,v1,v2).
- A pixel is covered iff w0>=0, w1>=0 and w2>=0.
- State machine:
  - IDLE: on start, register the vertices, raise busy, go to SETUP.
  - SETUP: compute integer coordinates, area and the raw bounding box (min/max over the three vertices); go to CLAMP.
  - CLAMP:
    - If area<=0: status=1, go to DONE.
    - Otherwise clamp the box to [0,FB_WIDTH-1] x [0,FB_HEIGHT-1].
    - If xmin>xmax or ymin>ymax: status=2, go to DONE.
    - Otherwise go to EDGE_INIT.
  - EDGE_INIT: evaluate w0..w2 at (xmin,ymin) into both the row-start and current registers; go to SCAN.
  - SCAN: evaluates one candidate pixel per cycle.
    - A covered pixel loads the output register (frag_valid=1).
    - An uncovered pixel just advances.
    - While frag_valid && !frag_ready, SCAN stalls: the candidate and all outputs are held stable.
    - Step x+1: each w += -(by-ay) of its edge.
    - End of row: x=xmin, y+1, each row-start w += (bx-ax), and current w takes the new row start.
    - After the pixel (xmax,ymax) is evaluated and any pending fragment is accepted: status=0, go to DONE.
  - DONE: pulse done, drop busy, go to IDLE.
- Latency:
  - First candidate is evaluated 4 cycles after the start cycle.
  - First fragment is visible 5 cycles after start if (xmin,ymin) is covered.
  - Rejected triangles pulse done 3 cycles after start.
- Throughput: one candidate per cycle with frag_ready held high.
- A start that arrives while busy is ignored, with no effect on the current triangle.

Decomposition:
- Shared package (raster_pkg):
  - Q16.16 shift constant (16) and the fixed-point ONE constant.
  - Status enum {RAST_OK=0, RAST_CULLED=1, RAST_OFFSCREEN=2}.
  - Fragment struct {x, y, w[3], area}.
- One sub-module, edge_eval: combinational edge(a,b,p) plus step-x/step-y coefficient generation.
  - Instantiated three times, once per edge.

Test Plan:
- Fragment coverage:
  - Stimulus: verts (10,10), (20,10), (10,20) as 0x000A0000 etc., frag_ready=1.
  - Required: area=100, exactly 66 fragments, all with x>=10, y>=10, x+y<=30, in raster order.
  - First fragment (10,10) with w=(100,0,0); status=0; done pulses once.
- Back-face cull:
  - Stimulus: same triangle with v1/v2 swapped.
  - Required: no fragments; done 3 cycles after start; status=1.
- Off-screen rejection:
  - Stimulus: verts (400,10), (410,10), (400,20).
  - Required: status=2; no fragments.
- Partial clipping to the framebuffer:
  - Stimulus: verts (-5,-5), (5,-5), (-5,5).
  - Required: only pixels with x,y>=0 and x+y<=0 are emitted, i.e. exactly one fragment, (0,0).
- Backpressure:
  - Stimulus: 66-pixel case with frag_ready toggled 1-of-3 cycles.
  - Required: identical fragment sequence; frag_x/frag_y/frag_w stable while stalled.
- Reset and repeat:
  - Stimulus: assert rst_in low mid-scan, then issue a new start.
  - Required: outputs zero immediately during reset; the new triangle rasterizes correctly from its own first pixel.
